// File: rtl/aes_dec128.sv
`timescale 1ns/1ps
// aes_dec128: iterative AES-128 ECB decryptor (FIPS-197 inverse cipher).
// The key is expanded forward to K10, which is optionally cached. Round keys
// K9..K0 are then regenerated backwards on the fly, so no round-key table is
// held. Each round takes 4 word-serial InvSubBytes cycles plus 1 mix cycle.
module aes_dec128 #(
  parameter int CACHE_KEY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] input_block,
  output logic         busy,
  output logic         done,
  output logic [127:0] output_block
);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, SUB, MIX} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte b lives at [127-8b -: 8]; state row r, column c is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_t       state;
  logic [3:0]   round;       // doubles as the KEYEXP step counter
  logic [1:0]   word_ctr;
  logic         cache_valid;
  logic [127:0] block, rk, key_lat, cached_key, cached_k10;

  logic [3:0]   rcon_idx;
  logic [31:0]  ks_word, ks_sub, fwd0, fwd1, fwd2, fwd3, sub_in, sub_out;
  logic [127:0] rk_fwd, rk_bwd, blk_sub, blk_mix;
  logic         cache_hit;

  assign cache_hit = (CACHE_KEY != 0) && cache_valid && (key == cached_key);

  // Shared key-schedule S-box word plus forward/backward steps and round datapath.
  always_comb begin
    rcon_idx = round;
    if (state == INIT) rcon_idx = 4'd9;
    else if (state != KEYEXP) rcon_idx = round - 4'd1;
    ks_word = (state == KEYEXP) ? rk[31:0] : (rk[31:0] ^ rk[63:32]);
    ks_sub  = sub_word({ks_word[23:0], ks_word[31:24]}) ^ {rcon(rcon_idx), 24'h000000};
    fwd0    = rk[127:96] ^ ks_sub;
    fwd1    = rk[95:64] ^ fwd0;
    fwd2    = rk[63:32] ^ fwd1;
    fwd3    = rk[31:0] ^ fwd2;
    rk_fwd  = {fwd0, fwd1, fwd2, fwd3};
    rk_bwd  = {rk[127:96] ^ ks_sub, rk[95:64] ^ rk[127:96], rk[63:32] ^ rk[95:64], ks_word};
    sub_in  = block[127:96];
    case (word_ctr)
      2'd0: sub_in = block[127:96];
      2'd1: sub_in = block[95:64];
      2'd2: sub_in = block[63:32];
      2'd3: sub_in = block[31:0];
    endcase
    sub_out = inv_sub_word(sub_in);
    blk_sub = block;
    case (word_ctr)
      2'd0: blk_sub[127:96] = sub_out;
      2'd1: blk_sub[95:64]  = sub_out;
      2'd2: blk_sub[63:32]  = sub_out;
      2'd3: blk_sub[31:0]   = sub_out;
    endcase
    blk_mix = inv_shift_rows(inv_mix_columns(block ^ rk));
  end

  // Control FSM, handshake outputs and cache valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      output_block <= '0;
      cache_valid  <= 1'b0;
      round        <= 4'd0;
      word_ctr     <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          round <= 4'd0;
          state <= cache_hit ? INIT : KEYEXP;
        end
        KEYEXP: begin
          round <= round + 4'd1;
          if (round == 4'd9) begin
            state <= INIT;
            if (CACHE_KEY != 0) cache_valid <= 1'b1;
          end
        end
        INIT: begin
          round    <= 4'd9;
          word_ctr <= 2'd0;
          state    <= SUB;
        end
        SUB: begin
          word_ctr <= word_ctr + 2'd1;
          if (word_ctr == 2'd3) state <= MIX;
        end
        MIX: begin
          if (round == 4'd0) begin
            output_block <= block ^ rk;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            round <= round - 4'd1;
            state <= SUB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Block, round key and key cache contents (data only, no reset).
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        key_lat <= key;
        block   <= input_block;
        rk      <= cache_hit ? cached_k10 : key;
      end
      KEYEXP: begin
        rk <= rk_fwd;
        if ((CACHE_KEY != 0) && (round == 4'd9)) begin
          cached_key <= key_lat;
          cached_k10 <= rk_fwd;
        end
      end
      INIT: begin
        block <= inv_shift_rows(block ^ rk);
        rk    <= rk_bwd;
      end
      SUB: block <= blk_sub;
      MIX: if (round != 4'd0) begin
        block <= blk_mix;
        rk    <= rk_bwd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_dec128.sv
`timescale 1ns/1ps
// tb_aes_dec128: directed FIPS-197 vectors, start-while-busy, mid-operation
// reset and encrypt/decrypt loopback against a behavioural AES-128 encryptor.
module tb_aes_dec128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] input_block = '0;
  logic         busy;
  logic         done;
  logic [127:0] output_block;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  aes_dec128 #(.CACHE_KEY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .input_block(input_block),
    .busy(busy), .done(done), .output_block(output_block)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference forward cipher; S-box table built by the generator walk in the initial block.
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // One decryption: push expectation, start, count edges to done, pop and compare.
  // With inject set, extra start pulses with other key/ct land at cycles 5 and 30.
  task automatic do_op(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] exp_pt,
                       input int exp_lat, input bit inject, input string tag);
    int lat;
    bit busy_ok;
    logic [127:0] exp;
    @(negedge clk);
    key = k; input_block = ct; start = 1'b1;
    exp_q.push_back(exp_pt);
    @(negedge clk);
    start = 1'b0;
    busy_ok = (busy === 1'b1);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (inject && (n == 5 || n == 30)) begin
        start = 1'b1; key = K_C1; input_block = CT_C1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_busy_held"}, 128'(busy_ok), 128'd1);
    if (lat > 0) begin
      chk({tag, "_busy_at_done"}, 128'(busy), 128'd0);
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 128'd0, 128'd1);
      else begin
        exp = exp_q.pop_front();
        chk({tag, "_pt"}, output_block, exp);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 128'(done), 128'd0);
      chk({tag, "_pt_hold"}, output_block, exp_pt);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    logic [7:0]   p, q;
    logic [127:0] rk_l, rp, rc_l;
    int ndone;

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_out", output_block, 128'd0);
    rst = 1'b0;

    // FIPS-197 vectors, cache miss / miss / hit
    do_op(K_C1, CT_C1, PT_C1, 61, 1'b0, "c1_miss");
    do_op(K_B, CT_B, PT_B, 61, 1'b0, "b_miss");
    do_op(K_B, CT_B, PT_B, 51, 1'b0, "b_hit");

    // Starts while busy are ignored; no second done follows
    do_op(K_B, CT_B, PT_B, 51, 1'b1, "busy_start");
    ndone = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("busy_start_extra_done", 128'(ndone), 128'd0);

    // Reset at cycle 20 aborts the operation and invalidates the cache
    @(negedge clk);
    key = K_B; input_block = CT_B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_out", output_block, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", 128'(ndone), 128'd0);
    do_op(K_B, CT_B, PT_B, 61, 1'b0, "post_abort");

    // Loopback: every fourth block reuses the previous key (cache hit)
    rk_l = K_B;
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 != 3) rk_l = {$urandom, $urandom, $urandom, $urandom};
      rp   = {$urandom, $urandom, $urandom, $urandom};
      rc_l = aes_enc(rk_l, rp);
      do_op(rk_l, rc_l, rp, (i % 4 == 3) ? 51 : 61, 1'b0, $sformatf("loop%0d", i));
    end

    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
